// File: rtl/imem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_arbiter_if                                              |
// | Description : Requester and memory-side signals of the instruction-memory |
// |               arbiter. Directions in names are as seen by the arbiter.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface imem_arbiter_if;
    // Fetch requester
    logic        f_req_i;
    logic [31:0] f_addr_i;
    logic        f_gnt_o;
    logic        f_rvalid_o;
    logic [15:0] f_rdata_o;
    logic        f_err_o;

    // Debug requester
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [15:0] d_rdata_o;
    logic        d_err_o;

    // Instruction memory
    logic [31:0] mem_pc_o;
    logic [15:0] mem_data_i;

    modport slave (
        input  f_req_i, f_addr_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
        input  d_req_i, d_addr_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_pc_o,
        input  mem_data_i
    );

    modport master (
        output f_req_i, f_addr_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
        output d_req_i, d_addr_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_pc_o,
        output mem_data_i
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_arbiter                                                 |
// | Description : Fixed-priority fetch/debug arbiter for the single registered |
// |               instruction-memory read port, with debug starvation guard.  |
// |               Optional: IMEM_ARB_ALIGN_CHECK_EN flags odd-address reads.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module imem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    imem_arbiter_if.slave bus
);

    localparam logic [7:0] C_MAX_WAIT = MAX_WAIT[7:0];

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } own_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    own_e        own_q,       own_d;
    logic [7:0]  starve_q,    starve_d;
    logic [31:0] last_addr_q, last_addr_d;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic        mis_q,       mis_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic        w_d_starved;
    logic        w_f_gnt;
    logic        w_d_gnt;
    logic [31:0] w_mem_pc;
    logic [15:0] w_rsp_data;
    logic        w_rsp_err;
    logic        w_f_rvalid;
    logic        w_d_rvalid;

    // Arbitration; rst_ni gating keeps grants low for the whole reset window.
    always_comb begin
        w_d_starved = (starve_q == C_MAX_WAIT) && bus.d_req_i;
        w_f_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        if (rst_ni) begin
            if (w_d_starved) begin
                w_d_gnt = 1'b1;
            end else if (bus.f_req_i) begin
                w_f_gnt = 1'b1;
            end else if (bus.d_req_i) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_mem_pc = last_addr_q;
        if (w_f_gnt) begin
            w_mem_pc = bus.f_addr_i;
        end else if (w_d_gnt) begin
            w_mem_pc = bus.d_addr_i;
        end
    end

    // Next-state: owner, idle address hold and starvation counter.
    always_comb begin
        own_d       = OWN_NONE;
        last_addr_d = w_mem_pc;
        starve_d    = starve_q;
        if (w_f_gnt) begin
            own_d = OWN_F;
        end else if (w_d_gnt) begin
            own_d = OWN_D;
        end

        if (w_d_gnt) begin
            starve_d = 8'd0;
        end else if (bus.d_req_i && (starve_q != C_MAX_WAIT)) begin
            starve_d = starve_q + 8'd1;
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    always_comb begin
        mis_d = (w_f_gnt || w_d_gnt) && w_mem_pc[0];
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            own_q       <= OWN_NONE;
            starve_q    <= 8'd0;
            last_addr_q <= 32'd0;
        end else begin
            own_q       <= own_d;
            starve_q    <= starve_d;
            last_addr_q <= last_addr_d;
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Response routing: only the owner sees data, everything else reads zero.
    // ------------------------------------------------------------------------
    always_comb begin
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        w_rsp_data = mis_q ? 16'h0000 : bus.mem_data_i;
        w_rsp_err  = mis_q;
`else
        w_rsp_data = bus.mem_data_i;
        w_rsp_err  = 1'b0;
`endif
        w_f_rvalid = (own_q == OWN_F);
        w_d_rvalid = (own_q == OWN_D);
    end

    assign bus.f_gnt_o    = w_f_gnt;
    assign bus.d_gnt_o    = w_d_gnt;
    assign bus.mem_pc_o   = w_mem_pc;

    assign bus.f_rvalid_o = w_f_rvalid;
    assign bus.f_rdata_o  = w_f_rvalid ? w_rsp_data : 16'h0000;
    assign bus.f_err_o    = w_f_rvalid && w_rsp_err;

    assign bus.d_rvalid_o = w_d_rvalid;
    assign bus.d_rdata_o  = w_d_rvalid ? w_rsp_data : 16'h0000;
    assign bus.d_err_o    = w_d_rvalid && w_rsp_err;

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single registered read port of the instruction memory between two requesters: the core fetch stage (port F) and the debug/readback unit (port D). Fetch has fixed priority. A starvation counter guarantees debug a grant after a bounded wait. The block sits between the core and the instruction memory; the memory takes a byte address and returns `{mem[a+1], mem[a]}` one clock after the address is presented.

## Interface
- `MAX_WAIT`, default 4: consecutive lost cycles after which D wins arbitration; legal range 1..255.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `f_req_i`  in  1  fetch request.
- `f_addr_i`  in  32  fetch byte address.
- `f_gnt_o`  out  1  fetch grant (combinational).
- `f_rvalid_o`  out  1  fetch response valid.
- `f_rdata_o`  out  16  fetch instruction.
- `f_err_o`  out  1  fetch response error.
- `d_req_i`, `d_addr_i`, `d_gnt_o`, `d_rvalid_o`, `d_rdata_o`, `d_err_o`: same widths and meanings as the fetch ports, for the debug requester.
- `mem_pc_o`  out  32  address to the instruction memory.
- `mem_data_i`  in  16  registered memory read data.

## Operation
- **Arbitration**, evaluated combinationally each cycle:
  - If `starve_q == MAX_WAIT` and `d_req_i` is high, D wins.
  - Otherwise F wins if `f_req_i` is high, else D wins if `d_req_i` is high, else there is no grant.
  - At most one of `f_gnt_o` / `d_gnt_o` is high. A grant is never issued without its request.
- **Memory address.** `mem_pc_o` is the winner's address. With no grant it holds the last granted address in `last_addr_q`, which resets to 0.
- **Starvation counter** `starve_q`, 8 bits, reset 0:
  - Clears on a D grant.
  - Increments (saturating at `MAX_WAIT`) when `d_req_i` is high and D is not granted.
  - Otherwise holds.
- **Response path:**
  - The owner register `own_q` is updated every cycle with the encoding {NONE, F, D}; it resets to NONE.
  - In the cycle after a grant, the owner's `rvalid` is 1 and its `rdata` equals `mem_data_i`.
  - The non-owner's `rvalid` is 0 and its `rdata` is 16'h0000.
- **Back-to-back grants are legal.** Each port has at most one response in flight, and that response always lands exactly one cycle after its grant.
- **Requester contract.** A requester may change `addr` or drop `req` at any time. Only the granted cycle's address is used.
- **Reset values:** all `rvalid`/`err` outputs 0, both `rdata` 0, `mem_pc_o` 0, `starve_q` 0, `own_q` NONE.
- **Reset mid-operation.** Asserting reset mid-operation discards any pending response: no `rvalid` is issued for a grant made in the cycle reset asserts.
- **Grants during reset.** Grants are suppressed (0) while `rst_ni` is low.

## Timing
- Grant to `rvalid`: exactly 1 cycle. Throughput is one access per cycle, shared between the two ports.
- **Fetch with continuous debug contention.** F is granted for `MAX_WAIT` consecutive cycles. D is granted in the next cycle, then F resumes.
- **Simultaneous requests** with `starve_q < MAX_WAIT`: F wins and `starve_q` increments.
- **D wins while F requests:** F gets no grant that cycle. F has no starvation counter, because D cannot win twice in a row while starved (its counter clears).
- **Counter ceiling.** `starve_q` saturates at `MAX_WAIT` and never wraps.

## Configuration
- **`IMEM_ARB_ALIGN_CHECK_EN` defined:**
  - A granted request whose address has bit 0 set is still granted and still drives `mem_pc_o`.
  - Its response has `err` = 1 and `rdata` = 16'h0000.
  - The misalignment flag is registered alongside `own_q`.
- **Not defined:** odd addresses pass through unchanged, `err` outputs are tied to 0, and `rdata` is always `mem_data_i` for the owner.

## Test plan
- **Fetch only.** Reset, then `f_req`=1 with `f_addr`=0x10. Require `f_gnt`=1 the same cycle, then next cycle `f_rvalid`=1 and `f_rdata`=`{mem[0x11],mem[0x10]}`; `d_rvalid`=0 throughout.
- **Starvation.** `MAX_WAIT`=4 with `f_req` and `d_req` held high from cycle 0. Require F granted in cycles 0–3, D granted in cycle 4 with `d_rvalid` in cycle 5, and F granted in cycle 5.
- **Idle hold.** Grant F at 0x20, then drop all requests for 3 cycles. Require `mem_pc_o` to stay 0x20 and no `rvalid` after the first response.
- **Reset mid-operation.** Grant D at 0x40, then assert `rst_ni`=0 in the same cycle. Require `d_rvalid`=0 the next cycle, and `starve_q`/`mem_pc_o` = 0.
- **Misaligned address, `IMEM_ARB_ALIGN_CHECK_EN` defined.** F at 0x13. Require `f_rvalid`=1, `f_err`=1, `f_rdata`=0x0000. With the macro undefined, require `f_err`=0 and `f_rdata`=`{mem[0x14],mem[0x13]}`.
- **Alternating traffic.** `d_req` only, then `f_req` only, on alternating cycles. Require every request granted the same cycle and each response routed only to its owner.
